// File: rtl/dma_ic_rd_ch.sv
// Instruction-cache line fetch channel: queues icache miss addresses and runs one memory
// read at a time, returning each line (or zeros on timeout) to the icache in request order.
module dma_ic_rd_ch #(
  parameter int dw      = 128,
  parameter int aw      = 33,
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [aw-1:0] ic_read_dma_addr_i,
  input  logic          ic_read_dma_valid_i,
  output logic          ic_read_dma_ack_o,
  output logic [aw-1:0] ic_read_addr_to_ic_o,
  output logic [dw-1:0] ic_read_dma_data_o,
  output logic [aw-1:0] mem_rd_addr_o,
  output logic          mem_rd_req_o,
  input  logic          mem_rd_gnt_i,
  input  logic [dw-1:0] mem_rd_data_i,
  input  logic          mem_rd_data_valid_i,
  output logic          ovf_o,
  output logic          tmo_o
);

  localparam int          PW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW:0] QFULL    = (PW+1)'(QDEPTH);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e        state_q, state_d;

  logic [aw-1:0] q_mem [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          q_empty, q_full, push, pop, drop;
  logic [aw-1:0] line_addr;

  logic [7:0]    wcnt_q, wcnt_d;
  logic          resp_ld, tmo_hit;
  logic [aw-1:0] mem_addr_q, resp_addr_q;
  logic [dw-1:0] resp_data_q;
  logic          ack_q, ovf_q, tmo_q;

  assign line_addr = ic_read_dma_addr_i & ~aw'('hF);
  assign q_empty   = (cnt_q == '0);
  assign q_full    = (cnt_q == QFULL);
  assign pop       = (state_q == IDLE) && !q_empty;
  // A full queue still takes the new request when its head leaves in the same cycle.
  assign push      = ic_read_dma_valid_i && !rst && (!q_full || pop);
  assign drop      = ic_read_dma_valid_i && !rst && q_full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; pointers and count alone define which
  // entries are live, so the array can map onto plain flops or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= line_addr;
  end

  // NOTE: every always_comb output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    resp_ld = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: if (!q_empty) state_d = REQ;
      REQ: begin
        if (mem_rd_gnt_i) begin
          state_d = WAIT;
          wcnt_d  = '0;
        end
      end
      WAIT: begin
        if (mem_rd_data_valid_i) begin
          state_d = RESP;
          resp_ld = 1'b1;
        end else if (wcnt_q == TMO_LAST) begin
          state_d = RESP;
          resp_ld = 1'b1;
          tmo_hit = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      mem_addr_q  <= '0;
      resp_addr_q <= '0;
      resp_data_q <= '0;
      ack_q       <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        mem_addr_q <= q_mem[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + 1'b1;
      end
      if (resp_ld) begin
        resp_addr_q <= mem_addr_q;
        resp_data_q <= tmo_hit ? '0 : mem_rd_data_i;
      end
      ack_q <= (state_q == RESP);
      if (drop)    ovf_q <= 1'b1;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end

  assign mem_rd_req_o         = (state_q == REQ);
  assign mem_rd_addr_o        = mem_addr_q;
  assign ic_read_dma_ack_o    = ack_q;
  assign ic_read_addr_to_ic_o = resp_addr_q;
  assign ic_read_dma_data_o   = resp_data_q;
  assign ovf_o                = ovf_q;
  assign tmo_o                = tmo_q;

endmodule

// File: tb/tb_dma_ic_rd_ch.sv
// Bench for dma_ic_rd_ch: directed scenarios plus a randomized phase, all checked against an
// in-order expected-response queue and a bench-side memory responder.
module tb_dma_ic_rd_ch;

  localparam int DW  = 128;
  localparam int AW  = 33;
  localparam int QD  = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ic_read_dma_addr_i;
  logic          ic_read_dma_valid_i;
  logic          ic_read_dma_ack_o;
  logic [AW-1:0] ic_read_addr_to_ic_o;
  logic [DW-1:0] ic_read_dma_data_o;
  logic [AW-1:0] mem_rd_addr_o;
  logic          mem_rd_req_o;
  logic          mem_rd_gnt_i;
  logic [DW-1:0] mem_rd_data_i;
  logic          mem_rd_data_valid_i;
  logic          ovf_o;
  logic          tmo_o;

  always #5 clk = ~clk;

  dma_ic_rd_ch #(.dw(DW), .aw(AW), .QDEPTH(QD), .TIMEOUT(TMO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ic_read_dma_addr_i   (ic_read_dma_addr_i),
    .ic_read_dma_valid_i  (ic_read_dma_valid_i),
    .ic_read_dma_ack_o    (ic_read_dma_ack_o),
    .ic_read_addr_to_ic_o (ic_read_addr_to_ic_o),
    .ic_read_dma_data_o   (ic_read_dma_data_o),
    .mem_rd_addr_o        (mem_rd_addr_o),
    .mem_rd_req_o         (mem_rd_req_o),
    .mem_rd_gnt_i         (mem_rd_gnt_i),
    .mem_rd_data_i        (mem_rd_data_i),
    .mem_rd_data_valid_i  (mem_rd_data_valid_i),
    .ovf_o                (ovf_o),
    .tmo_o                (tmo_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_ack = 0;
  int ack_cyc = 0;
  int req_cycles = 0;

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];

  bit            auto_en = 0, gnt_en = 0, dv_en = 0, fixed_en = 0, rand_en = 0, pend = 0;
  int            gnt_dly = 0, dv_dly = 0, gcnt = 0, wcnt = 0;
  logic [DW-1:0] fixed_data = '0;

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: observe outputs at the falling edge, then let the memory model choose inputs.
  task automatic cycle();
    logic [DW-1:0] d;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (ic_read_dma_ack_o) begin
      n_ack++;
      ack_cyc = cyc;
      if (exp_addr.size() == 0) check("unexpected_ack", 128'(ic_read_dma_ack_o), 128'(0));
      else begin
        check("ack_addr", 128'(ic_read_addr_to_ic_o), 128'(exp_addr.pop_front()));
        if (exp_data.size() == 0) check("ack_without_data", 128'(ic_read_dma_ack_o), 128'(0));
        else check("ack_data", ic_read_dma_data_o, exp_data.pop_front());
      end
    end
    if (mem_rd_req_o) begin
      req_cycles++;
      if (exp_addr.size() == 0) check("unexpected_req", 128'(mem_rd_req_o), 128'(0));
      else check("mem_addr", 128'(mem_rd_addr_o), 128'(exp_addr[0]));
    end
    ic_read_dma_valid_i = 1'b0;
    mem_rd_gnt_i        = 1'b0;
    mem_rd_data_valid_i = 1'b0;
    if (rst) begin
      pend = 0;
      gcnt = 0;
      wcnt = 0;
    end else if (auto_en) begin
      if (mem_rd_req_o) begin
        if (gnt_en && gcnt >= gnt_dly) begin
          mem_rd_gnt_i = 1'b1;
          gcnt = 0;
          wcnt = 0;
          pend = 1;
          if (rand_en) dv_dly = $urandom_range(0, 5);
        end else begin
          gcnt++;
        end
      end else if (pend && dv_en) begin
        if (wcnt >= dv_dly) begin
          d = fixed_en ? fixed_data : rand_line();
          mem_rd_data_valid_i = 1'b1;
          mem_rd_data_i = d;
          exp_data.push_back(d);
          pend = 0;
          if (rand_en) gnt_dly = $urandom_range(0, 4);
        end else begin
          wcnt++;
        end
      end
    end
  endtask

  task automatic send(logic [AW-1:0] a, bit expect_ack);
    ic_read_dma_valid_i = 1'b1;
    ic_read_dma_addr_i  = a;
    if (expect_ack) exp_addr.push_back(a & ~AW'('hF));
  endtask

  task automatic wait_acks(string tag, int target, int budget);
    int k = 0;
    while (n_ack < target && k < budget) begin
      cycle();
      k++;
    end
    check({"ack_count_", tag}, 128'(n_ack), 128'(target));
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ack"},  128'(ic_read_dma_ack_o), 128'(0));
    check({tag, "_req"},  128'(mem_rd_req_o), 128'(0));
    check({tag, "_raddr"}, 128'(ic_read_addr_to_ic_o), 128'(0));
    check({tag, "_data"}, ic_read_dma_data_o, 128'(0));
    check({tag, "_maddr"}, 128'(mem_rd_addr_o), 128'(0));
    check({tag, "_ovf"},  128'(ovf_o), 128'(0));
    check({tag, "_tmo"},  128'(tmo_o), 128'(0));
  endtask

  initial begin
    int t0, base, rbase, issued, k;
    logic [AW-1:0] a;

    rst = 1'b1;
    ic_read_dma_addr_i  = '0;
    ic_read_dma_valid_i = 1'b0;
    mem_rd_gnt_i        = 1'b0;
    mem_rd_data_i       = '0;
    mem_rd_data_valid_i = 1'b0;

    // Reset: outputs cleared, valids during reset ignored.
    repeat (3) begin
      send(33'h0_0000_0040, 0);
      cycle();
    end
    check_all_zero("reset");
    rst = 1'b0;
    rbase = req_cycles;
    repeat (6) cycle();
    check("valid_in_reset_ignored", 128'(req_cycles - rbase), 128'(0));

    // Single read with minimum latency.
    auto_en = 1; gnt_en = 1; dv_en = 1; gnt_dly = 0; dv_dly = 0;
    fixed_en = 1; fixed_data = {16{8'hA5}};
    t0 = cyc;
    send(33'h0_0000_1234, 1);
    wait_acks("single", 1, 40);
    check("single_latency", 128'(ack_cyc - t0), 128'(5));
    cycle();
    check("ack_one_cycle", 128'(ic_read_dma_ack_o), 128'(0));
    repeat (3) cycle();
    check("hold_addr", 128'(ic_read_addr_to_ic_o), 128'(33'h0_0000_1230));
    check("hold_data", ic_read_dma_data_o, {16{8'hA5}});
    check("ovf_clear", 128'(ovf_o), 128'(0));
    fixed_en = 0;

    // Overflow: six back-to-back valids with grant held off; the sixth is dropped.
    gnt_en = 0;
    base = n_ack;
    for (int i = 0; i < 6; i++) begin
      send(AW'(i * 16), i < 5);
      cycle();
    end
    check("ovf_set", 128'(ovf_o), 128'(1));
    gnt_en = 1;
    wait_acks("ovf", base + 5, 300);
    repeat (10) cycle();
    check("ovf_no_extra_ack", 128'(n_ack), 128'(base + 5));

    // Grant backpressure: request held for 10 cycles, a second push arrives meanwhile.
    gnt_dly = 10;
    base = n_ack;
    rbase = req_cycles;
    send(33'h1_2345_6780, 1);
    cycle();
    repeat (4) cycle();
    send(33'h0_0BAD_F00D, 1);
    wait_acks("bp", base + 2, 300);
    check("bp_req_cycles", 128'(req_cycles - rbase), 128'(22));
    gnt_dly = 0;

    // Timeout: no data ever returns; zeros after TMO wait cycles, late data ignored.
    check("tmo_clear", 128'(tmo_o), 128'(0));
    dv_en = 0;
    base = n_ack;
    exp_data.push_back('0);
    t0 = cyc;
    send(33'h0_0000_ABCD, 1);
    wait_acks("tmo", base + 1, 60);
    check("tmo_latency", 128'(ack_cyc - t0), 128'(5 + TMO - 1));
    check("tmo_set", 128'(tmo_o), 128'(1));
    pend = 0;
    cycle();
    mem_rd_data_valid_i = 1'b1;
    mem_rd_data_i = rand_line();
    repeat (10) cycle();
    check("tmo_late_data_ignored", 128'(n_ack), 128'(base + 1));

    // Reset while waiting on memory: transaction abandoned, late data ignored.
    base = n_ack;
    send(33'h0_0000_5550, 1);
    repeat (3) cycle();
    rst = 1'b1;
    exp_addr.delete();
    exp_data.delete();
    send(33'h0_0000_7770, 0);
    cycle();
    check_all_zero("rst_wait");
    send(33'h0_0000_7780, 0);
    cycle();
    rst = 1'b0;
    mem_rd_data_valid_i = 1'b1;
    mem_rd_data_i = rand_line();
    rbase = req_cycles;
    repeat (10) cycle();
    check("rst_wait_no_ack", 128'(n_ack), 128'(base));
    check("rst_wait_no_req", 128'(req_cycles - rbase), 128'(0));
    dv_en = 1;
    send(33'h0_0000_8880, 1);
    wait_acks("after_rst", base + 1, 40);

    // Randomized traffic, never more than QD requests outstanding.
    rand_en = 1;
    base = n_ack;
    issued = 0;
    k = 0;
    while ((issued < 40 || n_ack - base < 40) && k < 3000) begin
      if (issued < 40 && (issued - (n_ack - base)) < QD && $urandom_range(0, 1) == 1) begin
        a = AW'({$urandom(), $urandom()});
        send(a, 1);
        issued++;
      end
      cycle();
      k++;
    end
    check("rand_acks", 128'(n_ack - base), 128'(40));
    check("rand_ovf", 128'(ovf_o), 128'(0));
    check("rand_tmo", 128'(tmo_o), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_ic_rd_ch.md
DMA_IC_RD_CH -- requirements
Module: dma_ic_rd_ch

Interface
REQ-001 Parameter dw, default 128, width of the instruction data word.
REQ-002 Parameter aw, default 33, width of the byte address.
REQ-003 Parameter QDEPTH, default 4, depth of the request queue; power of two, minimum 2.
REQ-004 Parameter TIMEOUT, default 255, maximum number of WAIT cycles; legal range 1..255.
REQ-005 clk  input  1  single clock; all logic is on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 ic_read_dma_addr_i  input  aw  icache miss address; bits [3:0] ignored.
REQ-008 ic_read_dma_valid_i  input  1  request strobe; each high cycle is one request.
REQ-009 ic_read_dma_ack_o  output  1  one-cycle response pulse.
REQ-010 ic_read_addr_to_ic_o  output  aw  address of the returned line, with [3:0]=0.
REQ-011 ic_read_dma_data_o  output  dw  returned 128-bit line.
REQ-012 mem_rd_addr_o  output  aw  memory read address, with [3:0]=0.
REQ-013 mem_rd_req_o  output  1  memory read request; held high until granted.
REQ-014 mem_rd_gnt_i  input  1  memory accepts the request in any cycle where both req and gnt are high.
REQ-015 mem_rd_data_i  input  dw  memory read data.
REQ-016 mem_rd_data_valid_i  input  1  mem_rd_data_i is valid in this cycle.
REQ-017 ovf_o  output  1  sticky flag: a request was dropped because the queue was full.
REQ-018 tmo_o  output  1  sticky flag: a memory read timed out.

Function
REQ-019 Request queue:
- In each cycle with ic_read_dma_valid_i=1 and the queue not full, the block SHALL push {addr[aw-1:4],4'b0}.
- If the queue is full, the request SHALL be dropped and ovf_o set.
- A push and a pop in the same cycle SHALL both take effect.
- A full queue that pops in the same cycle SHALL accept the push.
REQ-020 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP.
REQ-021 IDLE: if the queue is non-empty, the block SHALL pop the head into mem_rd_addr_o and go to REQ the next cycle; otherwise it SHALL stay in IDLE.
REQ-022 REQ: mem_rd_req_o=1 and mem_rd_addr_o is stable; on mem_rd_gnt_i=1 the block SHALL go to WAIT and clear the wait counter.
REQ-023 WAIT:
- On mem_rd_data_valid_i=1, the block SHALL register the data and address and go to RESP.
- Otherwise it SHALL increment the counter.
- When the counter reaches TIMEOUT, it SHALL register data=0, set tmo_o and go to RESP.
REQ-024 RESP: ic_read_dma_ack_o=1 for exactly one cycle, with data and address valid; the next state SHALL be IDLE.
REQ-025 ic_read_dma_data_o and ic_read_addr_to_ic_o SHALL hold their last values until the next RESP.
REQ-026 At most one memory read SHALL be outstanding at a time.
REQ-027 mem_rd_data_valid_i SHALL be ignored outside WAIT, including a late return after a timeout.
REQ-028 Responses SHALL be returned in request order.
REQ-029 Minimum latency: a valid at cycle 0 with gnt in the first REQ cycle and data_valid in the first WAIT cycle SHALL give ack at cycle 5.
- Cycle 1: queue holds the entry.
- Cycle 2: REQ.
- Cycle 3: WAIT.
- Cycle 4: data registered.
- Cycle 5: RESP.
REQ-030 mem_rd_req_o SHALL be high only in REQ.

Reset
REQ-031 While rst=1:
- the FSM SHALL be forced to IDLE;
- the queue SHALL be emptied and the wait counter cleared;
- all outputs SHALL be 0, including ovf_o and tmo_o.
REQ-032 A reset in REQ or WAIT SHALL abandon the transaction, with no ack ever issued for it.
REQ-033 Memory data arriving after reset SHALL be ignored.
REQ-034 ic_read_dma_valid_i SHALL be ignored in any cycle where rst=1.

Verification
REQ-035 Single read:
- Stimulus: valid with addr 33'h0_0000_1234; gnt immediately; data_valid in the first WAIT cycle with data 128'hA5...A5.
- Response: mem_rd_addr_o=33'h0_0000_1230; ack at cycle 5, address 33'h0_0000_1230, data A5...A5.
REQ-036 Queue overflow:
- Stimulus: 6 consecutive valids (addr 0x00, 0x10, ... 0x50) with gnt held low.
- Response: 4 entries accepted, plus 1 more after the first pop; ovf_o=1; exactly 5 acks, in order 0x00..0x40.
REQ-037 Timeout:
- Stimulus: gnt given, data_valid never asserted, TIMEOUT=8.
- Response: ack with data 0 after 8 WAIT cycles; tmo_o=1; a later data_valid produces no ack.
REQ-038 Grant backpressure:
- Stimulus: gnt delayed 10 cycles.
- Response: mem_rd_req_o high and mem_rd_addr_o stable for all 10 cycles; a push arriving during this is queued, not lost.
REQ-039 Reset in WAIT:
- Stimulus: rst pulse while in WAIT, then data_valid.
- Response: no ack; all outputs 0; the next request completes normally.
